// File: rtl/nn_input_framer_pkg.sv
// Shared constants and types for the network front end: the input width,
// the network's fixed pipeline latency, and the sample/class payload types.
package nn_input_framer_pkg;

  localparam int unsigned IN_SIZE_1  = 4;
  // One registered stage each in dense_layer_1..4 and final_layer
  localparam int unsigned NN_LATENCY = 5;
  localparam int unsigned SAMPLE_W   = 16;

  typedef logic [15:0] sample_t;
  typedef logic [1:0]  class_t;

endpackage

// File: rtl/nn_input_framer_result.sv
// Tracks the network latency after each vector swap. It holds busy for that
// time, captures the class output and emits a one-cycle result strobe.
module nn_result_tracker #(
  parameter int unsigned NN_LATENCY = nn_input_framer_pkg::NN_LATENCY
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic [1:0] class_i,
  output logic       busy_o,
  output logic       result_valid_o,
  output logic [1:0] result_class_o
);
  import nn_input_framer_pkg::*;

  localparam int unsigned CNT_W = $clog2(NN_LATENCY + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             valid_q, valid_d;
  class_t           class_q, class_d;

  // Counter reaches zero in the last cycle of the hold; capture on that edge.
  always_comb begin
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    valid_d = 1'b0;
    class_d = class_q;
    if (start_i) begin
      busy_d = 1'b1;
      cnt_d  = CNT_W'(NN_LATENCY);
    end else if (busy_q) begin
      if (cnt_q == '0) begin
        busy_d  = 1'b0;
        valid_d = 1'b1;
        class_d = class_i;
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      class_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      class_q <= class_d;
    end
  end

  assign busy_o         = busy_q;
  assign result_valid_o = valid_q;
  assign result_class_o = class_q;

endmodule

// File: rtl/nn_input_framer.sv
// Double-buffered framer: fills a bank from the sample stream and presents
// complete frames to top_nn. The frame is held stable until the result is sampled.
module nn_input_framer #(
  parameter int unsigned FRAME_LEN  = nn_input_framer_pkg::IN_SIZE_1,
  parameter int unsigned NN_LATENCY = nn_input_framer_pkg::NN_LATENCY,
  parameter int unsigned SAMPLE_W   = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [SAMPLE_W-1:0]           sample_in,
  input  logic                          sample_valid,
  input  logic                          sample_sof,
  output logic                          sample_ready,
  output logic [SAMPLE_W*FRAME_LEN-1:0] input_vector,
  input  logic [1:0]                    class_in,
  output logic                          result_valid,
  output logic [1:0]                    result_class,
  output logic                          busy,
  output logic [7:0]                    frame_drop_cnt
);
  import nn_input_framer_pkg::*;

  localparam int unsigned IDX_W = $clog2(FRAME_LEN) + 1;

  logic [IDX_W-1:0]                   idx_q, idx_d, wr_idx;
  logic                               full_q, full_d;
  logic [FRAME_LEN-1:0][SAMPLE_W-1:0] fill_q, fill_d;
  logic [FRAME_LEN-1:0][SAMPLE_W-1:0] vec_q, vec_d;
  logic [7:0]                         drop_q, drop_d;
  logic                               accept, swap;

  assign sample_ready = !full_q;
  assign accept       = sample_valid && !full_q;
  assign swap         = full_q && !busy;

  // Accept and swap are exclusive: a full bank never accepts.
  always_comb begin
    idx_d  = idx_q;
    full_d = full_q;
    fill_d = fill_q;
    vec_d  = vec_q;
    drop_d = drop_q;
    wr_idx = sample_sof ? '0 : idx_q;
    if (accept) begin
      for (int i = 0; i < int'(FRAME_LEN); i++) begin
        if (wr_idx == IDX_W'(i)) fill_d[i] = sample_in;
      end
      if (sample_sof && (idx_q != '0) && (drop_q != 8'hFF)) drop_d = drop_q + 8'd1;
      if (wr_idx == IDX_W'(FRAME_LEN - 1)) begin
        full_d = 1'b1;
        idx_d  = '0;
      end else begin
        idx_d = wr_idx + IDX_W'(1);
      end
    end
    if (swap) begin
      vec_d  = fill_q;
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q  <= '0;
      full_q <= 1'b0;
      fill_q <= '0;
      vec_q  <= '0;
      drop_q <= '0;
    end else begin
      idx_q  <= idx_d;
      full_q <= full_d;
      fill_q <= fill_d;
      vec_q  <= vec_d;
      drop_q <= drop_d;
    end
  end

  assign input_vector   = vec_q;
  assign frame_drop_cnt = drop_q;

  nn_result_tracker #(
    .NN_LATENCY(NN_LATENCY)
  ) u_tracker (
    .clk           (clk),
    .rst           (rst),
    .start_i       (swap),
    .class_i       (class_in),
    .busy_o        (busy),
    .result_valid_o(result_valid),
    .result_class_o(result_class)
  );

endmodule
